// File: rtl/misr_param_compactor.sv
// Parametrised Galois-form MISR that compacts NPAT valid response samples after a start pulse
// and compares the final signature against a golden value.
module misr_param_compactor #(
  parameter int unsigned           WIDTH = 16,
  parameter int unsigned           NIN   = 3,
  parameter logic [WIDTH-1:0]      POLY  = WIDTH'(16'h002D),
  parameter logic [WIDTH-1:0]      SEED  = '0,
  parameter int unsigned           NPAT  = 256
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [NIN-1:0]   din,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] sig,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int unsigned CW = $clog2(NPAT + 1);
  localparam logic [CW-1:0] LAST = CW'(NPAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] din_ext;
  logic [WIDTH-1:0] sig_next;

  // One Galois folding step: shift, reduce by the feedback polynomial, then fold in the inputs.
  always_comb begin
    din_ext  = WIDTH'(din);
    sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din_ext;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      sig   <= SEED;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            sig   <= SEED;
            count <= '0;
            pass  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // start is deliberately ignored here; only valid samples advance the run.
          if (din_valid) begin
            sig   <= sig_next;
            count <= count + 1'b1;
            if (count == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == golden);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
